// File: rtl/regfile_wb_arbiter.sv
// Two-requester arbiter for the single register-file write port: MEM has priority,
// ALU is promoted after STARVE_MAX consecutive denials; writes to x0 are accepted but dropped.
module regfile_wb_arbiter #(
    parameter int DATA_W     = 64,
    parameter int ADDR_W     = 5,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    output logic              rf_regwrite,
    output logic [ADDR_W-1:0] rf_rd,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [1:0]        grant_src,
    output logic [3:0]        starve_cnt
);

    typedef enum logic {PRIO_MEM, PRIO_ALU} state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t            state;
    logic              alu_xfer_p0;
    logic              mem_xfer_p0;
    logic              vld_p0;
    logic              wr_en_p0;
    logic [ADDR_W-1:0] rd_p0;
    logic [DATA_W-1:0] data_p0;
    logic [3:0]        starve_nxt;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    // Ready is a function of the valids, the priority state and reset only.
    always_comb begin
        alu_ready = 1'b0;
        mem_ready = 1'b0;
        if (!reset) begin
            if (state == PRIO_ALU) begin
                alu_ready = alu_valid;
                mem_ready = mem_valid && !alu_valid;
            end else begin
                mem_ready = mem_valid;
                alu_ready = alu_valid && !mem_valid;
            end
        end
    end

    assign alu_xfer_p0 = alu_valid && alu_ready;
    assign mem_xfer_p0 = mem_valid && mem_ready;
    assign vld_p0      = alu_xfer_p0 || mem_xfer_p0;
    assign rd_p0       = alu_xfer_p0 ? alu_rd : mem_rd;
    assign data_p0     = alu_xfer_p0 ? alu_data : mem_data;
    assign wr_en_p0    = vld_p0 && (rd_p0 != '0);
    assign starve_nxt  = (!alu_valid || alu_ready) ? 4'd0 : sat_inc4(starve_cnt);

    // Stage p0 -> p1: accepted transfer becomes the registered write-port drive.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= PRIO_MEM;
            starve_cnt  <= 4'd0;
            rf_regwrite <= 1'b0;
            grant_src   <= 2'b00;
            rf_rd       <= '0;
            rf_wdata    <= '0;
        end else begin
            starve_cnt <= starve_nxt;
            case (state)
                PRIO_MEM: if (starve_nxt >= STARVE_LIM) state <= PRIO_ALU;
                PRIO_ALU: if (alu_xfer_p0 || !alu_valid) state <= PRIO_MEM;
                default:  state <= PRIO_MEM;
            endcase
            rf_regwrite <= wr_en_p0;
            grant_src   <= !wr_en_p0 ? 2'b00 : (alu_xfer_p0 ? 2'b01 : 2'b10);
            if (vld_p0) begin
                rf_rd    <= rd_p0;
                rf_wdata <= data_p0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table, reset corner sequences,
// and randomized handshake traffic against a service-order reference model.
module tb_regfile_wb_arbiter;

    localparam int DW = 64;
    localparam int AW = 5;
    localparam int SM = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          alu_valid, mem_valid;
    logic [AW-1:0] alu_rd, mem_rd;
    logic [DW-1:0] alu_data, mem_data;
    logic          alu_ready, mem_ready;
    logic          rf_regwrite;
    logic [AW-1:0] rf_rd;
    logic [DW-1:0] rf_wdata;
    logic [1:0]    grant_src;
    logic [3:0]    starve_cnt;

    regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .STARVE_MAX(SM)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .rf_regwrite(rf_regwrite), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
        .grant_src(grant_src), .starve_cnt(starve_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: ALU is owed service once it has been denied SM times in a row.
    int          m_cnt;
    bit          m_ar, m_mr, m_we;
    logic [4:0]  m_rd;
    logic [63:0] m_wd;
    logic [1:0]  m_src;
    logic [63:0] regs [32];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_ready();
        bit alu_owed;
        alu_owed = (m_cnt >= SM);
        if (reset) begin
            m_ar = 0; m_mr = 0;
        end else if (alu_owed) begin
            m_ar = alu_valid; m_mr = mem_valid && !alu_valid;
        end else begin
            m_mr = mem_valid; m_ar = alu_valid && !mem_valid;
        end
    endtask

    task automatic model_clock();
        if (reset) begin
            m_cnt = 0; m_we = 0; m_rd = 0; m_wd = 0; m_src = 0;
        end else begin
            if (alu_valid && !m_ar) m_cnt = (m_cnt >= 15) ? 15 : m_cnt + 1;
            else m_cnt = 0;
            if (m_ar) begin
                m_we = (alu_rd != 0); m_src = m_we ? 2'b01 : 2'b00;
                m_rd = alu_rd; m_wd = alu_data;
            end else if (m_mr) begin
                m_we = (mem_rd != 0); m_src = m_we ? 2'b10 : 2'b00;
                m_rd = mem_rd; m_wd = mem_data;
            end else begin
                m_we = 0; m_src = 0;
            end
        end
    endtask

    task automatic set_in(input bit rst, input bit av, input logic [4:0] ard, input logic [63:0] ad,
                          input bit mv, input logic [4:0] mrd, input logic [63:0] md);
        @(negedge clk);
        reset = rst; alu_valid = av; alu_rd = ard; alu_data = ad;
        mem_valid = mv; mem_rd = mrd; mem_data = md;
        #1;
        model_ready();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_clock();
        if (rf_regwrite) regs[rf_rd] = rf_wdata;
    endtask

    typedef struct {
        bit rst; bit av; logic [4:0] ard; logic [63:0] ad;
        bit mv; logic [4:0] mrd; logic [63:0] md;
        bit ear; bit emr; bit ewe; logic [4:0] erd; logic [63:0] ewd;
        logic [1:0] esrc; logic [3:0] ecnt; bit cdata;
    } vec_t;

    vec_t tbl [13];

    bit          a_pend, q_pend, rst_r;
    logic [4:0]  a_rd, q_rd;
    logic [63:0] a_d, q_d;

    initial begin
        reset = 1; alu_valid = 0; mem_valid = 0;
        alu_rd = 0; mem_rd = 0; alu_data = 0; mem_data = 0;
        m_cnt = 0; m_we = 0; m_rd = 0; m_wd = 0; m_src = 0; m_ar = 0; m_mr = 0;
        for (int i = 0; i < 32; i++) regs[i] = 0;

        //            rst av ard ad        mv mrd md       ar mr we rd wd        src cnt cd
        tbl[0]  = '{1, 1, 1, 64'h11,   1, 2, 64'h22,   0, 0, 0, 0, 64'h0,    0, 0, 1};
        tbl[1]  = '{1, 1, 1, 64'h11,   1, 2, 64'h22,   0, 0, 0, 0, 64'h0,    0, 0, 1};
        tbl[2]  = '{0, 1, 5, 64'h1234, 0, 0, 64'h0,    1, 0, 1, 5, 64'h1234, 1, 0, 1};
        tbl[3]  = '{0, 0, 0, 64'h0,    0, 0, 64'h0,    0, 0, 0, 5, 64'h1234, 0, 0, 1};
        tbl[4]  = '{0, 1, 3, 64'hA3,   1, 4, 64'hB4,   0, 1, 1, 4, 64'hB4,   2, 1, 1};
        tbl[5]  = '{0, 1, 3, 64'hA3,   1, 4, 64'hB4,   0, 1, 1, 4, 64'hB4,   2, 2, 1};
        tbl[6]  = '{0, 1, 3, 64'hA3,   1, 4, 64'hB4,   0, 1, 1, 4, 64'hB4,   2, 3, 1};
        tbl[7]  = '{0, 1, 3, 64'hA3,   1, 4, 64'hB4,   1, 0, 1, 3, 64'hA3,   1, 0, 1};
        tbl[8]  = '{0, 1, 3, 64'hA3,   1, 4, 64'hB4,   0, 1, 1, 4, 64'hB4,   2, 1, 1};
        tbl[9]  = '{0, 0, 0, 64'h0,    0, 0, 64'h0,    0, 0, 0, 4, 64'hB4,   0, 0, 1};
        tbl[10] = '{0, 0, 0, 64'h0,    1, 0, 64'hFF,   0, 1, 0, 0, 64'h0,    0, 0, 0};
        tbl[11] = '{0, 1, 7, 64'hA,    1, 7, 64'hB,    0, 1, 1, 7, 64'hB,    2, 1, 1};
        tbl[12] = '{0, 1, 7, 64'hA,    0, 0, 64'h0,    1, 0, 1, 7, 64'hA,    1, 0, 1};

        for (int i = 0; i < 13; i++) begin
            set_in(tbl[i].rst, tbl[i].av, tbl[i].ard, tbl[i].ad, tbl[i].mv, tbl[i].mrd, tbl[i].md);
            chk($sformatf("vec%0d alu_ready", i), 64'(alu_ready), 64'(tbl[i].ear));
            chk($sformatf("vec%0d mem_ready", i), 64'(mem_ready), 64'(tbl[i].emr));
            tick();
            chk($sformatf("vec%0d rf_regwrite", i), 64'(rf_regwrite), 64'(tbl[i].ewe));
            chk($sformatf("vec%0d grant_src", i), 64'(grant_src), 64'(tbl[i].esrc));
            chk($sformatf("vec%0d starve_cnt", i), 64'(starve_cnt), 64'(tbl[i].ecnt));
            if (tbl[i].cdata) begin
                chk($sformatf("vec%0d rf_rd", i), 64'(rf_rd), 64'(tbl[i].erd));
                chk($sformatf("vec%0d rf_wdata", i), rf_wdata, tbl[i].ewd);
            end
        end
        chk("same_rd last write x7", regs[7], 64'hA);

        // Reset right after an accepted MEM transfer discards the registered write.
        set_in(0, 0, 0, 0, 1, 9, 64'h99);
        chk("rst_mid mem_ready", 64'(mem_ready), 64'd1);
        tick();
        set_in(1, 1, 2, 64'h2, 1, 3, 64'h3);
        chk("rst_mid alu_ready", 64'(alu_ready), 64'd0);
        chk("rst_mid mem_ready_in_reset", 64'(mem_ready), 64'd0);
        tick();
        chk("rst_mid rf_regwrite", 64'(rf_regwrite), 64'd0);
        chk("rst_mid grant_src", 64'(grant_src), 64'd0);
        chk("rst_mid rf_rd", 64'(rf_rd), 64'd0);
        chk("rst_mid rf_wdata", rf_wdata, 64'd0);
        chk("rst_mid starve_cnt", 64'(starve_cnt), 64'd0);

        // Build ALU priority, then reset: MEM must win again afterwards.
        for (int i = 0; i < 3; i++) begin
            set_in(0, 1, 2, 64'h2, 1, 3, 64'h3);
            chk($sformatf("starve_build%0d mem_ready", i), 64'(mem_ready), 64'd1);
            tick();
        end
        chk("starve_build starve_cnt", 64'(starve_cnt), 64'd3);
        set_in(1, 1, 2, 64'h2, 1, 3, 64'h3);
        tick();
        set_in(0, 1, 2, 64'h2, 1, 3, 64'h3);
        chk("post_rst prio alu_ready", 64'(alu_ready), 64'd0);
        chk("post_rst prio mem_ready", 64'(mem_ready), 64'd1);
        tick();

        // Randomized traffic with holding requesters, ALU flushes and sporadic reset.
        a_pend = 0; q_pend = 0; a_rd = 0; q_rd = 0; a_d = 0; q_d = 0;
        for (int n = 0; n < 600; n++) begin
            if (!a_pend && ($urandom % 3 != 0)) begin
                a_pend = 1; a_rd = ($urandom % 8 == 0) ? 5'd0 : 5'($urandom);
                a_d = {$urandom, $urandom};
            end else if (a_pend && ($urandom % 25 == 0)) begin
                a_pend = 0;
            end
            if (!q_pend && ($urandom % 3 != 0)) begin
                q_pend = 1; q_rd = ($urandom % 8 == 0) ? 5'd0 : 5'($urandom);
                q_d = {$urandom, $urandom};
            end
            rst_r = ($urandom % 70 == 0);
            set_in(rst_r, a_pend, a_rd, a_d, q_pend, q_rd, q_d);
            chk("rnd alu_ready", 64'(alu_ready), 64'(m_ar));
            chk("rnd mem_ready", 64'(mem_ready), 64'(m_mr));
            tick();
            chk("rnd rf_regwrite", 64'(rf_regwrite), 64'(m_we));
            chk("rnd grant_src", 64'(grant_src), 64'(m_src));
            chk("rnd starve_cnt", 64'(starve_cnt), 64'(m_cnt));
            if (m_we || rst_r) begin
                chk("rnd rf_rd", 64'(rf_rd), 64'(m_rd));
                chk("rnd rf_wdata", rf_wdata, m_wd);
            end
            if (m_ar) a_pend = 0;
            if (m_mr) q_pend = 0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
